line_main_memory: RTL
=====================

# line_main_memory

Parametrised, line-oriented main-memory model that sits below the data/instruction caches of the pipelined RV32IM core. It serves whole-line refills, whole-line write-backs and single-word stores through a valid/ready request channel, with a fixed, configurable access latency. Responses carry an error flag for out-of-range addresses. Line addresses are always aligned to the line boundary.

## Interface
- DATA_W, 32: bits per memory word.
- ADDR_W, 32: request address width; word-addressed.
- DEPTH, 4096: number of words; power of two, multiple of LINE_WORDS.
- LINE_WORDS, 16: words per cache line; power of two, ≥2.
- LATENCY, 4: cycles from request acceptance to response; ≥1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_op  in  2  request type: 00 line read, 01 line write, 10 word write, 11 reserved (treated as line read).
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W*LINE_WORDS  line write data; word write uses bits [DATA_W-1:0].
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  DATA_W*LINE_WORDS  line read data; word i at [i*DATA_W +: DATA_W].
- resp_err  out  1  address out of range; valid with resp_valid.
- busy  out  1  high whenever not IDLE.

## Operation
- States: IDLE, WAIT, CLEAR (CLEAR exists only with the macro).
- IDLE: req_ready=1. Handshake is req_valid && req_ready at a rising edge. On handshake, capture op, addr and wdata, load cnt=LATENCY-1, go to WAIT.
- WAIT: req_ready=0. Decrement cnt each edge. At the edge where cnt==0, perform the access, register the response and return to IDLE.
- Line base address is req_addr with the low log2(LINE_WORDS) bits cleared.
- Line read: word i of resp_rdata = mem[base+i].
- Line write: mem[base+i] = wdata word i. resp_rdata = 0.
- Word write: mem[req_addr] = wdata[DATA_W-1:0]. The address is not aligned. resp_rdata = 0.
- Range check: a request is out of range when the full req_addr ≥ DEPTH.
  - Result: no memory write, resp_rdata = 0, resp_err = 1.
- Write and read both commit at the same edge (the response edge). A read accepted after a write always sees the written data.
- Inputs are ignored outside the handshake. The captured wdata is used even if the inputs change later.

## Timing
- Request accepted at edge E0 → resp_valid high for exactly one cycle, registered at edge E_LATENCY.
- req_ready is low from E0 until E_LATENCY. It returns high in the same cycle as resp_valid.
- The next request can be accepted at E_LATENCY+1, so the peak rate is one request per LATENCY+1 cycles.
- There is no response backpressure. resp_rdata and resp_err hold their values until the next response.
- Reset (any edge with reset=1) forces:
  - state IDLE, cnt=0
  - resp_valid=0, resp_rdata=0, resp_err=0
  - busy=0, req_ready=1 in the following cycle
- Reset during WAIT aborts the request. A pending write is not committed and no resp_valid is produced.
- Reset dominates a simultaneous handshake: the request is dropped.

## Configuration
- MAIN_MEM_CLEAR_ON_RESET_EN defined: reset enters CLEAR instead of IDLE.
  - CLEAR zeroes one line per cycle, line 0 through DEPTH/LINE_WORDS-1, using a line counter.
  - busy=1 and req_ready=0 throughout CLEAR. The block goes to IDLE after the last line (DEPTH/LINE_WORDS cycles).
  - Reset during CLEAR restarts the sweep from line 0.
- Not defined: reset leaves memory contents untouched. Contents power up undefined.

## Test plan
Defaults are used, with LATENCY=4.
- Line write at addr 0x20 with word i = 0xA0000000+i, then line read at 0x2B:
  - resp_valid exactly 4 edges after each acceptance
  - words 0xA0000000..0xA000000F, resp_err=0
- Word write 0xDEADBEEF at 0x25, then line read at 0x20: word 5 = 0xDEADBEEF, all other words unchanged.
- Line read at 0x1000: resp_err=1, rdata=0. Line write at 0x1000, then read at 0xFF0: contents unchanged, resp_err=0.
- req_valid held high for two reads: accepted at E0 and E5 only; req_ready=0 during E1–E4; two resp_valid pulses at E4 and E9.
- Line write to 0x40 accepted, reset asserted 2 cycles later:
  - no resp_valid appears
  - a subsequent read of 0x40 returns the pre-write data (macro undefined)
- Macro defined, reset for one cycle:
  - busy=1 and req_ready=0 for 256 cycles
  - then a read of any previously written line returns all zeros

Source files
------------

// File: rtl/line_main_memory.sv
// Line-oriented main memory below the I/D caches: line refill, line write-back and word store
// with fixed access latency. Define MAIN_MEM_CLEAR_ON_RESET_EN to zero the array after reset.
module line_main_memory #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 4096,
    parameter int LINE_WORDS = 16,
    parameter int LATENCY    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [1:0]                   req_op,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W*LINE_WORDS-1:0] req_wdata,
    output logic                         resp_valid,
    output logic [DATA_W*LINE_WORDS-1:0] resp_rdata,
    output logic                         resp_err,
    output logic                         busy
);

    // state   | meaning
    // IDLE    | ready for a request
    // WAIT    | latency countdown; access commits when cnt reaches zero
    // CLEAR   | post-reset sweep zeroing one line per cycle (clear build only)

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int LINE_W = DATA_W * LINE_WORDS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

`ifdef MAIN_MEM_CLEAR_ON_RESET_EN
    localparam int     LINES       = DEPTH / LINE_WORDS;
    localparam int     LC_W        = (LINES > 1) ? $clog2(LINES) : 1;
    localparam state_t RESET_STATE = S_CLEAR;
`else
    localparam state_t RESET_STATE = S_IDLE;
`endif

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [1:0]          op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                do_access;
    logic                addr_err;
    logic                is_read;
    logic                wr_line;
    logic                wr_word;
    logic [IDX_W-1:0]    line_base;
    logic [LINE_W-1:0]   line_rd;

`ifdef MAIN_MEM_CLEAR_ON_RESET_EN
    logic [LC_W-1:0]     clr_line_q;
    logic                clr_last;
    logic [IDX_W-1:0]    clr_base;

    assign clr_last = (clr_line_q == LC_W'(LINES - 1));
    assign clr_base = IDX_W'({clr_line_q, {OFF_W{1'b0}}});
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = S_WAIT;
            S_WAIT:  if (cnt_q == '0) state_d = S_IDLE;
`ifdef MAIN_MEM_CLEAR_ON_RESET_EN
            S_CLEAR: if (clr_last) state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
    end

    assign accept    = req_valid && req_ready;
    assign do_access = (state_q == S_WAIT) && (cnt_q == '0);
    assign addr_err  = ({1'b0, addr_q} >= (ADDR_W + 1)'(DEPTH));
    assign is_read   = (op_q == 2'b00) || (op_q == 2'b11);
    assign wr_line   = do_access && !addr_err && (op_q == 2'b01) && !reset;
    assign wr_word   = do_access && !addr_err && (op_q == 2'b10) && !reset;
    assign line_base = {addr_q[IDX_W-1:OFF_W], {OFF_W{1'b0}}};

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= CNT_W'(LATENCY - 1);
        end else if ((state_q == S_WAIT) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Request capture; later input changes must not affect the pending access
    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

`ifdef MAIN_MEM_CLEAR_ON_RESET_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_line_q <= '0;
        end else if (state_q == S_CLEAR) begin
            clr_line_q <= clr_line_q + 1'b1;
        end
    end
`endif

    always_comb begin
        line_rd = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            line_rd[i*DATA_W +: DATA_W] = mem[line_base + IDX_W'(i)];
        end
    end

    // Storage array has no reset; contents persist across reset in the default build
    always_ff @(posedge clk) begin
`ifdef MAIN_MEM_CLEAR_ON_RESET_EN
        if (!reset && (state_q == S_CLEAR)) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                mem[clr_base + IDX_W'(i)] <= '0;
            end
        end else
`endif
        if (wr_line) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                mem[line_base + IDX_W'(i)] <= wdata_q[i*DATA_W +: DATA_W];
            end
        end else if (wr_word) begin
            mem[addr_q[IDX_W-1:0]] <= wdata_q[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= do_access;
            if (do_access) begin
                resp_err   <= addr_err;
                resp_rdata <= (is_read && !addr_err) ? line_rd : '0;
            end
        end
    end

endmodule
